// File: rtl/dcache_line_ctrl.sv
// dcache_line_ctrl: line refill / writeback sequencer for the data-cache memblock.
// On a line miss the controller takes the memblock port (flush_mode=1). If the victim is dirty,
// each victim word is read from the memblock and written to memory. The new line is then
// requested from memory and streamed into the memblock.
//
// Handshake rules, for all memory-side signals:
//   mem_rdreq / mem_wrreq are held high, with mem_addr and mem_wdata stable, until the cycle in
//   which mem_ack is sampled high. An ack in the first cycle of a request is accepted, so each
//   request lasts at least one cycle. An ack in any other state is ignored. mem_rdata_valid is
//   acted on only in FILL_DATA; one refill word is accepted on every cycle it is high, and gaps
//   of any length are allowed. miss_req is sampled only in IDLE. The requester holds it until
//   miss_done.
module dcache_line_ctrl #(
    parameter int DATABITS      = 32,
    parameter int CACHEADDRBITS = 5,
    parameter int LINEWORDS     = 8,
    parameter int ADDRBITS      = 32
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          miss_req,
    input  logic [CACHEADDRBITS-$clog2(LINEWORDS)-1:0]    miss_index,
    input  logic [ADDRBITS-1:0]                           miss_addr,
    input  logic                                          victim_dirty,
    input  logic [ADDRBITS-1:0]                           victim_addr,
    output logic                                          busy,
    output logic                                          miss_done,
    output logic                                          flush_mode,
    output logic [CACHEADDRBITS-1:0]                      flush_addr,
    output logic                                          flush_write,
    output logic                                          line_in_valid,
    input  logic [DATABITS-1:0]                           cache_rdata,
    output logic [ADDRBITS-1:0]                           mem_addr,
    output logic                                          mem_rdreq,
    output logic                                          mem_wrreq,
    output logic [DATABITS-1:0]                           mem_wdata,
    input  logic                                          mem_ack,
    input  logic                                          mem_rdata_valid,
    output logic [2:0]                                    dbg_state
);

    localparam int BPW     = DATABITS / 8;
    localparam int LW      = $clog2(LINEWORDS);
    localparam int BB      = $clog2(BPW);
    localparam int IDXBITS = CACHEADDRBITS - LW;
    localparam int ALIGN   = LW + BB;

    // Byte-offset bits within one line. Masking them off gives a line-aligned address.
    localparam logic [ADDRBITS-1:0] OFF_MASK = ADDRBITS'((64'd1 << ALIGN) - 64'd1);
    localparam logic [LW-1:0]       LAST_CNT = LW'(LINEWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WB_RD     = 3'd1,
        S_WB_WR     = 3'd2,
        S_FILL_REQ  = 3'd3,
        S_FILL_DATA = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t               r_state;
    logic [IDXBITS-1:0]   r_index;
    logic [LW-1:0]        r_word_cnt;
    logic [ADDRBITS-1:0]  r_miss_addr;
    logic [ADDRBITS-1:0]  r_victim_addr;
    logic                 r_busy;
    logic                 r_flush_mode;
    logic                 r_flush_write;
    logic                 r_miss_done;
    logic                 r_mem_rdreq;
    logic                 r_mem_wrreq;
    logic [ADDRBITS-1:0]  r_mem_addr;
    logic [DATABITS-1:0]  r_mem_wdata;
    logic                 r_wb_load;

    logic [ADDRBITS-1:0]  w_miss_line;
    logic [ADDRBITS-1:0]  w_victim_line;
    logic [ADDRBITS-1:0]  w_wb_offset;
    logic [ADDRBITS-1:0]  w_wb_addr;
    logic                 w_last_word;

    assign w_miss_line   = miss_addr & ~OFF_MASK;
    assign w_victim_line = victim_addr & ~OFF_MASK;
    // The victim base is line aligned, so adding the word offset never carries out of the line.
    // The sum still wraps modulo 2^ADDRBITS.
    assign w_wb_offset   = ADDRBITS'({r_word_cnt, {BB{1'b0}}});
    assign w_wb_addr     = r_victim_addr + w_wb_offset;
    assign w_last_word   = (r_word_cnt == LAST_CNT);

    // Sequencer. All outputs except line_in_valid and the first-cycle wdata bypass are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_index       <= '0;
            r_word_cnt    <= '0;
            r_miss_addr   <= '0;
            r_victim_addr <= '0;
            r_busy        <= 1'b0;
            r_flush_mode  <= 1'b0;
            r_flush_write <= 1'b0;
            r_miss_done   <= 1'b0;
            r_mem_rdreq   <= 1'b0;
            r_mem_wrreq   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_wb_load     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (miss_req) begin
                        r_index       <= miss_index;
                        r_miss_addr   <= w_miss_line;
                        r_victim_addr <= w_victim_line;
                        r_word_cnt    <= '0;
                        r_busy        <= 1'b1;
                        r_flush_mode  <= 1'b1;
                        if (victim_dirty) begin
                            r_state <= S_WB_RD;
                        end else begin
                            r_state     <= S_FILL_REQ;
                            r_mem_rdreq <= 1'b1;
                            r_mem_addr  <= w_miss_line;
                        end
                    end
                end

                // The memblock samples flush_addr at the end of this cycle.
                // Its data appears on cache_rdata during the first WB_WR cycle.
                S_WB_RD: begin
                    r_state     <= S_WB_WR;
                    r_mem_wrreq <= 1'b1;
                    r_mem_addr  <= w_wb_addr;
                    r_wb_load   <= 1'b1;
                end

                S_WB_WR: begin
                    r_wb_load <= 1'b0;
                    if (r_wb_load) begin
                        r_mem_wdata <= cache_rdata;
                    end
                    if (mem_ack) begin
                        r_mem_wrreq <= 1'b0;
                        if (w_last_word) begin
                            r_state     <= S_FILL_REQ;
                            r_word_cnt  <= '0;
                            r_mem_rdreq <= 1'b1;
                            r_mem_addr  <= r_miss_addr;
                        end else begin
                            r_state    <= S_WB_RD;
                            r_word_cnt <= r_word_cnt + LW'(1);
                            r_mem_addr <= '0;
                        end
                    end
                end

                S_FILL_REQ: begin
                    if (mem_ack) begin
                        r_state       <= S_FILL_DATA;
                        r_mem_rdreq   <= 1'b0;
                        r_mem_addr    <= '0;
                        r_word_cnt    <= '0;
                        r_flush_write <= 1'b1;
                    end
                end

                S_FILL_DATA: begin
                    if (mem_rdata_valid) begin
                        r_word_cnt <= r_word_cnt + LW'(1);
                        if (w_last_word) begin
                            r_state       <= S_DONE;
                            r_flush_write <= 1'b0;
                            r_miss_done   <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_miss_done  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_flush_mode <= 1'b0;
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_busy        <= 1'b0;
                    r_flush_mode  <= 1'b0;
                    r_flush_write <= 1'b0;
                    r_miss_done   <= 1'b0;
                    r_mem_rdreq   <= 1'b0;
                    r_mem_wrreq   <= 1'b0;
                    r_wb_load     <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign miss_done     = r_miss_done;
    assign flush_mode    = r_flush_mode;
    assign flush_addr    = {r_index, r_word_cnt};
    assign flush_write   = r_flush_write;
    // Refill words go into the memblock in the same cycle they arrive.
    assign line_in_valid = (r_state == S_FILL_DATA) && mem_rdata_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_rdreq     = r_mem_rdreq;
    assign mem_wrreq     = r_mem_wrreq;
    // In the first WB_WR cycle the word is only on cache_rdata, so it is passed straight through.
    // From the second cycle on, the captured copy is driven. Both are the same word, so mem_wdata
    // stays stable for the whole request.
    assign mem_wdata     = r_wb_load ? cache_rdata : r_mem_wdata;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_dcache_line_ctrl.sv
// tb_dcache_line_ctrl: directed bench for the line refill / writeback sequencer.
// It models a 32-word memblock with 1-cycle read latency and a memory responder with
// configurable ack delay and refill gaps.
module tb_dcache_line_ctrl;

    logic        clk;
    logic        reset_n;
    logic        miss_req;
    logic [1:0]  miss_index;
    logic [31:0] miss_addr;
    logic        victim_dirty;
    logic [31:0] victim_addr;
    logic        busy;
    logic        miss_done;
    logic        flush_mode;
    logic [4:0]  flush_addr;
    logic        flush_write;
    logic        line_in_valid;
    logic [31:0] cache_rdata;
    logic [31:0] mem_addr;
    logic        mem_rdreq;
    logic        mem_wrreq;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        mem_rdata_valid;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;

    logic [31:0] mem_blk [32];
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];

    typedef struct {
        logic        dirty;
        logic [1:0]  idx;
        logic [31:0] miss_addr;
        logic [31:0] victim_addr;
        int          ack_dly;
        int          gap;
        logic        pulse;
        logic [31:0] exp_fill_addr;
        logic [31:0] exp_wb_base;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];
    vec_t v_after_rst;

    dcache_line_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .miss_req        (miss_req),
        .miss_index      (miss_index),
        .miss_addr       (miss_addr),
        .victim_dirty    (victim_dirty),
        .victim_addr     (victim_addr),
        .busy            (busy),
        .miss_done       (miss_done),
        .flush_mode      (flush_mode),
        .flush_addr      (flush_addr),
        .flush_write     (flush_write),
        .line_in_valid   (line_in_valid),
        .cache_rdata     (cache_rdata),
        .mem_addr        (mem_addr),
        .mem_rdreq       (mem_rdreq),
        .mem_wrreq       (mem_wrreq),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata_valid (mem_rdata_valid),
        .dbg_state       (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memblock model: registered read, write on flush_write & line_in_valid
    always @(posedge clk) begin
        cache_rdata <= mem_blk[flush_addr];
        if (flush_mode && flush_write && line_in_valid) begin
            mem_blk[flush_addr] <= mem_rdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic logic [31:0] pre_word(input logic [1:0] idx, input int k);
        return 32'hA500_0000 | (32'(idx) << 8) | 32'(k);
    endfunction

    function automatic logic [31:0] fill_word(input logic [31:0] maddr, input int k);
        return 32'hD000_0000 ^ maddr ^ (32'(k) * 32'h0101_0011);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},        32'(busy), 0);
        check({tag, "_miss_done"},   32'(miss_done), 0);
        check({tag, "_flush_mode"},  32'(flush_mode), 0);
        check({tag, "_flush_write"}, 32'(flush_write), 0);
        check({tag, "_line_in_vld"}, 32'(line_in_valid), 0);
        check({tag, "_mem_rdreq"},   32'(mem_rdreq), 0);
        check({tag, "_mem_wrreq"},   32'(mem_wrreq), 0);
        check({tag, "_flush_addr"},  32'(flush_addr), 0);
        check({tag, "_mem_addr"},    mem_addr, 0);
        check({tag, "_mem_wdata"},   mem_wdata, 0);
    endtask

    // Driver + responder for one complete miss transaction
    task automatic run_txn(input vec_t v);
        int cyc, held, gap_ctr, nfill, wr0;
        logic done;
        logic [31:0] hold_addr, hold_data, ea, ed;
        cyc = 0; held = 0; gap_ctr = 0; nfill = 0; done = 1'b0;
        hold_addr = '0; hold_data = '0;
        @(negedge clk);
        if (v.dirty) begin
            for (int k = 0; k < 8; k++) begin
                mem_blk[{v.idx, 3'(k)}] <= pre_word(v.idx, k);
                exp_addr_q.push_back(v.exp_wb_base + 32'(k * 4));
                exp_data_q.push_back(pre_word(v.idx, k));
            end
        end
        @(negedge clk);
        wr0 = wr_cnt;
        miss_index   = v.idx;
        miss_addr    = v.miss_addr;
        victim_addr  = v.victim_addr;
        victim_dirty = v.dirty;
        miss_req     = 1'b1;
        while (cyc < 400 && !done) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            mem_rdata_valid = 1'b0;
            if (v.pulse) miss_req = flush_write && (nfill == 3);
            if (mem_wrreq) begin
                if (held == 0) begin
                    hold_addr = mem_addr; hold_data = mem_wdata;
                end else begin
                    check("wb_addr_stable", mem_addr, hold_addr);
                    check("wb_data_stable", mem_wdata, hold_data);
                end
                if (held == v.ack_dly) begin
                    mem_ack = 1'b1;
                    held = 0;
                    if (exp_addr_q.size() == 0) begin
                        fail_now("unexpected_wb");
                    end else begin
                        ea = exp_addr_q.pop_front();
                        ed = exp_data_q.pop_front();
                        check("wb_addr", mem_addr, ea);
                        check("wb_data", mem_wdata, ed);
                    end
                end else begin
                    held++;
                end
            end else if (mem_rdreq) begin
                if (held == 0) hold_addr = mem_addr;
                else check("rd_addr_stable", mem_addr, hold_addr);
                if (held == v.ack_dly) begin
                    mem_ack = 1'b1;
                    held = 0;
                    check("fill_addr", mem_addr, v.exp_fill_addr);
                end else begin
                    held++;
                end
            end else if (flush_write) begin
                if (gap_ctr == 0) begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata = fill_word(v.miss_addr, nfill);
                    nfill++;
                    gap_ctr = v.gap;
                end else begin
                    gap_ctr--;
                end
            end
            if (miss_done) begin
                done = 1'b1;
                check("latency", 32'(cyc), 32'(v.exp_lat));
                miss_req = 1'b0;
            end
        end
        mem_ack = 1'b0;
        mem_rdata_valid = 1'b0;
        miss_req = 1'b0;
        if (!done) begin
            fail_now("txn_timeout");
            exp_addr_q.delete();
            exp_data_q.delete();
        end
        check("wb_left", 32'(exp_addr_q.size()), 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(negedge clk);
        check("post_flush_mode", 32'(flush_mode), 0);
        check("post_busy", 32'(busy), 0);
        check("done_single", 32'(miss_done), 0);
        check("fill_writes", 32'(wr_cnt - wr0), 8);
        for (int k = 0; k < 8; k++)
            check("line_data", mem_blk[{v.idx, 3'(k)}], fill_word(v.miss_addr, k));
        repeat (3) @(negedge clk);
        check("stay_idle", 32'(busy), 0);
    endtask

    // Reset, directed table, hand sequences, summary
    initial begin
        int cyc, nfill, wr0;
        logic seen_done;
        reset_n = 1'b0; miss_req = 1'b0; miss_index = '0; miss_addr = '0;
        victim_dirty = 1'b0; victim_addr = '0; mem_ack = 1'b0;
        mem_rdata_valid = 1'b0; mem_rdata = '0;

        //           dirty idx miss_addr      victim_addr   dly gap pulse exp_fill      exp_wb_base   lat
        vecs[0] = '{1'b0, 2'd2, 32'h0000_1000, 32'h0000_0000, 0, 0, 1'b0, 32'h0000_1000, 32'h0000_0000, 10};
        vecs[1] = '{1'b1, 2'd1, 32'h0000_3000, 32'h0000_2004, 0, 0, 1'b0, 32'h0000_3000, 32'h0000_2000, 26};
        vecs[2] = '{1'b1, 2'd3, 32'h0000_4010, 32'h0000_5020, 3, 2, 1'b0, 32'h0000_4000, 32'h0000_5020, 67};
        vecs[3] = '{1'b0, 2'd0, 32'h0000_601F, 32'h0000_0000, 3, 2, 1'b1, 32'h0000_6000, 32'h0000_0000, 27};
        vecs[4] = '{1'b1, 2'd2, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 0, 0, 1'b0, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 26};
        v_after_rst = '{1'b0, 2'd1, 32'h0000_7000, 32'h0000_0000, 0, 0, 1'b0, 32'h0000_7000, 32'h0000_0000, 10};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Stray ack / rdata_valid while idle must not start anything or write the memblock
        wr0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ack = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 32'hBAD0_0000;
            #1;
            check("idle_line_in_valid", 32'(line_in_valid), 0);
            @(negedge clk);
            check("idle_busy", 32'(busy), 0);
            check("idle_rdreq", 32'(mem_rdreq), 0);
        end
        mem_ack = 1'b0; mem_rdata_valid = 1'b0;
        @(negedge clk);
        check("idle_no_write", 32'(wr_cnt - wr0), 0);

        // Reset in the middle of a refill, after four words have been written
        @(negedge clk);
        wr0 = wr_cnt; nfill = 0; seen_done = 1'b0; cyc = 0;
        miss_index = 2'd1; miss_addr = 32'h0000_7000; victim_dirty = 1'b0; miss_req = 1'b1;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0; mem_rdata_valid = 1'b0;
            if (miss_done) seen_done = 1'b1;
            if (mem_rdreq) begin
                mem_ack = 1'b1;
            end else if (flush_write) begin
                if (nfill == 4) break;
                mem_rdata_valid = 1'b1;
                mem_rdata = 32'h5555_0000 + 32'(nfill);
                nfill++;
            end
        end
        if (cyc >= 100) fail_now("rst_seq_timeout");
        reset_n = 1'b0; miss_req = 1'b0; mem_rdata_valid = 1'b1;
        #1;
        check_all_zero("midrst");
        check("midrst_no_done", 32'(seen_done), 0);
        check("midrst_words", 32'(wr_cnt - wr0), 4);
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        reset_n = 1'b1;
        run_txn(v_after_rst);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
